// File: rtl/rb_bin_expander.sv
// Spreads one vector of per-RB values across a full FFT bin frame.
// Load phase captures NUM_RB words; emit phase streams FFT_LEN bins with guard/DC fill.
module rb_bin_expander #(
    parameter int FFT_LEN     = 1024,
    parameter int NUM_RB      = 50,
    parameter int BINS_PER_RB = 12,
    parameter int FIRST_BIN   = 212,
    parameter int SKIP_DC     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic [31:0] fill_value,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        o_err
);

    localparam int BW  = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
    localparam int RBW = (NUM_RB > 1) ? $clog2(NUM_RB) : 1;
    localparam int SBW = (BINS_PER_RB > 1) ? $clog2(BINS_PER_RB) : 1;

    localparam int unsigned DC       = FFT_LEN / 2;
    localparam int unsigned FB       = FIRST_BIN;
    localparam int unsigned SPAN_END = FIRST_BIN + NUM_RB * BINS_PER_RB;

    localparam logic [BW-1:0]  LAST_BIN = BW'(FFT_LEN - 1);
    localparam logic [RBW-1:0] RB_LAST  = RBW'(NUM_RB - 1);
    localparam logic [SBW-1:0] SB_LAST  = SBW'(BINS_PER_RB - 1);

    typedef enum logic {S_LOAD, S_EMIT} state_t;

    // With DC skipping the upper half of the span is shifted up by one bin
    function automatic logic bin_active(input logic [BW-1:0] b);
        int unsigned bi;
        bi = int'(b);
        if (SKIP_DC != 0)
            bin_active = (bi != DC) &&
                         (((bi >= FB) && (bi < DC)) || ((bi > DC) && (bi <= SPAN_END)));
        else
            bin_active = (bi >= FB) && (bi < SPAN_END);
    endfunction

    state_t          state_reg, state_next;
    logic [31:0]     rb_mem [NUM_RB];
    logic [31:0]     fill_reg, fill_next;
    logic [BW-1:0]   bin_reg, bin_next;
    logic [SBW-1:0]  sub_reg, sub_next;
    logic [RBW-1:0]  rb_reg, rb_next;
    logic            act_reg, act_next;
    logic [RBW-1:0]  wr_idx_reg, wr_idx_next;
    logic            wr_full_reg, wr_full_next;
    logic            ovf_reg, ovf_next;
    logic            i_tready_reg;
    logic [31:0]     o_tdata_reg, tdata_next;
    logic            o_tlast_reg, tlast_next;
    logic            o_tvalid_reg, tvalid_next;
    logic            o_err_reg, err_next;

    logic            in_hs, out_hs, wr_en, present;
    logic [BW-1:0]   pres_bin;
    logic [RBW-1:0]  pres_rb;
    logic [31:0]     pres_fill;

    assign in_hs  = i_tready_reg & i_tvalid;
    assign out_hs = o_tvalid_reg & o_tready;

    always_comb begin
        state_next   = state_reg;
        fill_next    = fill_reg;
        bin_next     = bin_reg;
        sub_next     = sub_reg;
        rb_next      = rb_reg;
        act_next     = act_reg;
        wr_idx_next  = wr_idx_reg;
        wr_full_next = wr_full_reg;
        ovf_next     = ovf_reg;
        tdata_next   = o_tdata_reg;
        tlast_next   = o_tlast_reg;
        tvalid_next  = o_tvalid_reg;
        err_next     = 1'b0;
        wr_en        = 1'b0;
        present      = 1'b0;
        pres_bin     = '0;
        pres_rb      = '0;
        pres_fill    = fill_reg;

        unique case (state_reg)
            S_LOAD: begin
                if (in_hs) begin
                    if (!wr_full_reg) begin
                        wr_en = 1'b1;
                        if (wr_idx_reg == RB_LAST)
                            wr_full_next = 1'b1;
                        else
                            wr_idx_next = wr_idx_reg + RBW'(1);
                    end else if (!ovf_reg) begin
                        ovf_next = 1'b1;
                        err_next = 1'b1;
                    end
                    if (i_tlast) begin
                        if (!wr_full_reg && (wr_idx_reg != RB_LAST))
                            err_next = 1'b1;
                        wr_idx_next  = '0;
                        wr_full_next = 1'b0;
                        ovf_next     = 1'b0;
                        state_next   = S_EMIT;
                        bin_next     = '0;
                        sub_next     = '0;
                        rb_next      = '0;
                        fill_next    = fill_value;
                        pres_fill    = fill_value;
                        present      = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (out_hs) begin
                    if (bin_reg == LAST_BIN) begin
                        state_next  = S_LOAD;
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        act_next    = 1'b0;
                    end else begin
                        // RB counters only move past bins that carried an RB value
                        if (act_reg) begin
                            if (sub_reg == SB_LAST) begin
                                sub_next = '0;
                                if (rb_reg != RB_LAST)
                                    rb_next = rb_reg + RBW'(1);
                            end else begin
                                sub_next = sub_reg + SBW'(1);
                            end
                        end
                        bin_next = bin_reg + BW'(1);
                        pres_bin = bin_reg + BW'(1);
                        pres_rb  = rb_next;
                        present  = 1'b1;
                    end
                end
            end
            default: state_next = S_LOAD;
        endcase

        if (present) begin
            act_next    = bin_active(pres_bin);
            tvalid_next = 1'b1;
            tlast_next  = (pres_bin == LAST_BIN);
            // Forward the word being written this cycle so bin 0 can use the final RB
            if (act_next)
                tdata_next = (wr_en && (wr_idx_reg == pres_rb)) ? i_tdata : rb_mem[pres_rb];
            else
                tdata_next = pres_fill;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_LOAD;
            fill_reg     <= '0;
            bin_reg      <= '0;
            sub_reg      <= '0;
            rb_reg       <= '0;
            act_reg      <= 1'b0;
            wr_idx_reg   <= '0;
            wr_full_reg  <= 1'b0;
            ovf_reg      <= 1'b0;
            i_tready_reg <= 1'b0;
            o_tdata_reg  <= '0;
            o_tlast_reg  <= 1'b0;
            o_tvalid_reg <= 1'b0;
            o_err_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_reg     <= fill_next;
            bin_reg      <= bin_next;
            sub_reg      <= sub_next;
            rb_reg       <= rb_next;
            act_reg      <= act_next;
            wr_idx_reg   <= wr_idx_next;
            wr_full_reg  <= wr_full_next;
            ovf_reg      <= ovf_next;
            i_tready_reg <= (state_next == S_LOAD);
            o_tdata_reg  <= tdata_next;
            o_tlast_reg  <= tlast_next;
            o_tvalid_reg <= tvalid_next;
            o_err_reg    <= err_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RB; i++)
                rb_mem[i] <= '0;
        end else if (wr_en) begin
            rb_mem[wr_idx_reg] <= i_tdata;
        end
    end

    assign i_tready = i_tready_reg;
    assign o_tdata  = o_tdata_reg;
    assign o_tlast  = o_tlast_reg;
    assign o_tvalid = o_tvalid_reg;
    assign o_err    = o_err_reg;

endmodule

// File: doc/rb_bin_expander.md
# rb_bin_expander

Expands one vector of per-resource-block (RB) values into a full-length per-FFT-bin stream, so that each bin carries the value of the RB it belongs to. It is the inverse of the bin aggregator in the spectrum-sensing chain: the aggregator folds FFT bin energies into RB sums, and this block spreads RB-level quantities back onto the bin grid. Typical RB-level inputs are detection thresholds or occupancy flags, and the expanded stream feeds per-bin compare and mask stages. It sits on the RFNoC AXI-Stream datapath between the RB-domain processing and the bin-domain consumers.

## Interface
- FFT_LEN, 1024, bins per output frame.
- NUM_RB, 50, RB values per input frame.
- BINS_PER_RB, 12, bins covered by each RB.
- FIRST_BIN, 212, index of the first bin of RB0.
- SKIP_DC, 1, when 1 bin FFT_LEN/2 is a DC bin: it gets the fill value and the RB map continues at the next bin.
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- i_tdata  in  32  RB value.
- i_tlast  in  1  last RB of the vector.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- fill_value  in  32  value for guard and DC bins; sampled when the first output bin is presented.
- o_tdata  out  32  bin value.
- o_tlast  out  1  high on bin FFT_LEN-1.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- o_err  out  1  one-cycle pulse on a malformed input frame.

## Operation
- Storage: NUM_RB x 32 register array (rb_mem) plus a latched copy of fill_value.
- FSM states:
  - LOAD: i_tready=1, o_tvalid=0.
    - Each accepted word is written to rb_mem[wr_idx], then wr_idx increments.
    - An accepted word with i_tlast=1 moves the FSM to EMIT.
  - EMIT: i_tready=0, o_tvalid=1.
    - Each output handshake advances the bin counter.
    - The handshake on bin FFT_LEN-1 moves the FSM back to LOAD.
- Bin classification, using bin counter b with DC = FFT_LEN/2 and active span L = NUM_RB*BINS_PER_RB:
  - When SKIP_DC=1:
    - b == DC gives fill.
    - b in [FIRST_BIN, DC) or (DC, FIRST_BIN+L] gives an RB value.
    - Anything else gives fill.
  - When SKIP_DC=0: b in [FIRST_BIN, FIRST_BIN+L) gives an RB value; otherwise fill.
  - Defaults give bins 212..511 → RB0..24, bin 512 → fill, bins 513..812 → RB25..49, and bins 0..211 and 813..1023 → fill.
- RB index generation:
  - Incremental counters only, no divider.
  - A sub-counter runs 0..BINS_PER_RB-1, and the RB index increments when it wraps.
  - Both counters hold still while on a DC or fill bin.
  - Both counters clear at the start of EMIT.
- Frame errors:
  - Short frame (i_tlast on word k < NUM_RB-1): o_err pulses, and rb_mem[k+1..NUM_RB-1] keep their previous contents. EMIT proceeds normally.
  - Long frame (more than NUM_RB words before i_tlast): words beyond NUM_RB-1 are accepted and discarded. o_err pulses once, on the first excess word, and EMIT starts after i_tlast.
- Widths: counters are sized with $clog2(FFT_LEN) and $clog2(NUM_RB). Data is passed through unmodified with no arithmetic on it.

## Timing
- Reset (reset=0, asynchronous) gives:
  - State LOAD, all counters 0, rb_mem cleared to 0.
  - i_tready=0 while reset is asserted, then 1 from the first clk edge after release.
  - o_tvalid=0, o_tlast=0, o_tdata=0, o_err=0.
- Reset asserted in the middle of a frame aborts it immediately. No partial output follows, and the next frame starts clean.
- The last-input handshake at edge n gives o_tvalid=1 with bin 0 valid after edge n, i.e. one cycle of latency.
- The last-output handshake at edge m gives i_tready=1 after edge m.
- There is no overlap between load and emit; with continuous handshakes one frame takes NUM_RB+FFT_LEN cycles.
- o_tdata, o_tlast and o_tvalid are registered. They hold stable while o_tvalid=1 and o_tready=0 (AXI rule: no retraction).
- o_tvalid does not depend on o_tready. i_tready does not depend on i_tvalid.
- fill_value is latched on the LOAD→EMIT transition, and changes during EMIT have no effect.
- o_err is registered and asserts the cycle after the offending handshake.

## Test plan
- Defaults. Load rb[i]=i+1 (50 words, tlast on word 49), fill_value=0xFFFF_FFFF, o_tready=1. Required output:
  - 1024 words with tlast only on word 1023.
  - Bins 0..211 = 0xFFFF_FFFF; bin 212 = 1; bin 223 = 1; bin 224 = 2; bin 511 = 25; bin 512 = 0xFFFF_FFFF; bin 513 = 26; bin 812 = 50; bin 813..1023 = 0xFFFF_FFFF.
  - o_err never asserts.
- Backpressure. Same frame with o_tready toggled randomly at 50% → identical sequence; o_tdata and o_tlast are stable during every stalled cycle.
- Short then long frame:
  - Frame A is 50 words of 0xA. Frame B is 20 words of 0xB with tlast on word 19.
  - Frame B gives one o_err pulse; bins for RB0..19 = 0xB and bins for RB20..49 = 0xA.
  - Frame C is 55 words: o_err pulses on word 50, and the output uses words 0..49 only.
- SKIP_DC=0, FFT_LEN=64, NUM_RB=4, BINS_PER_RB=12, FIRST_BIN=8 → bins 8..55 map to RB0..3 in groups of 12; bin 32 carries RB2 and is not fill.
- Reset mid-EMIT. Assert reset at bin 300 → o_tvalid falls immediately; after release i_tready=1 and rb_mem reads 0 (a full frame of zeros followed by an expand shows 0 in all RB bins).
- Throughput. Two back-to-back frames with continuous valid/ready → 2*(50+1024) cycles total, with a single-cycle turnaround between phases and no lost words.
